// File: rtl/sig_gen_pkg.sv
// Shared constants and types for the signal generator AXI4-Lite register file.
// Register indices, AXI response codes and the packed configuration bundle.
package sig_gen_pkg;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_FREQ    = 2'd1;
    localparam logic [1:0] REG_AMPL    = 2'd2;
    localparam logic [1:0] REG_OFFSET  = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [31:0] ctrl;
        logic [31:0] freq;
        logic [31:0] ampl;
        logic [31:0] offset;
    } sig_gen_cfg_t;

    function automatic logic [31:0] cfg_field(sig_gen_cfg_t c, logic [1:0] idx);
        logic [31:0] r;
        r = c.offset;
        case (idx)
            REG_CTRL: r = c.ctrl;
            REG_FREQ: r = c.freq;
            REG_AMPL: r = c.ampl;
            default:  r = c.offset;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sig_gen_axil_wr_ctl.sv
// AXI4-Lite write control: one-beat AW and W slots, commit detection and
// the B handshake. All handshake outputs are registered.
module sig_gen_axil_wr_ctl
    import sig_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  aw_idx,
    input  logic        aw_valid,
    output logic        aw_ready,
    input  logic [31:0] w_data,
    input  logic [3:0]  w_strb,
    input  logic        w_valid,
    output logic        w_ready,
    output logic        b_valid,
    input  logic        b_ready,
    output logic        wr_commit,
    output logic [1:0]  wr_idx,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_strb
);

    logic        aw_full_q, aw_full_d;
    logic        w_full_q, w_full_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  strb_q, strb_d;
    logic        bvalid_q, bvalid_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        aw_hs, w_hs, commit;

    always_comb begin
        aw_hs     = aw_valid && awready_q;
        w_hs      = w_valid && wready_q;
        commit    = aw_full_q && w_full_q;
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        idx_d     = idx_q;
        data_d    = data_q;
        strb_d    = strb_q;
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end else begin
            if (aw_hs) begin
                aw_full_d = 1'b1;
                idx_d     = aw_idx;
            end
            if (w_hs) begin
                w_full_d = 1'b1;
                data_d   = w_data;
                strb_d   = w_strb;
            end
        end
        bvalid_d = bvalid_q;
        if (commit) begin
            bvalid_d = 1'b1;
        end else if (b_ready) begin
            bvalid_d = 1'b0;
        end
        // Readies look ahead at next state so they can stay registered.
        awready_d = !aw_full_d && !bvalid_d;
        wready_d  = !w_full_d && !bvalid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            idx_q     <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
        end else begin
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            bvalid_q  <= bvalid_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
        end
    end

    assign aw_ready  = awready_q;
    assign w_ready   = wready_q;
    assign b_valid   = bvalid_q;
    assign wr_commit = commit;
    assign wr_idx    = idx_q;
    assign wr_data   = data_q;
    assign wr_strb   = strb_q;

endmodule

// File: rtl/sig_gen_axil_regs.sv
// AXI4-Lite register file for the signal generator (CTRL/FREQ/AMPL/OFFSET).
// Define SIG_GEN_AXIL_STRB_EN to honour wstrb byte lanes on writes.
module sig_gen_axil_regs
    import sig_gen_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [31:0]                     cfg_ctrl,
    output logic [31:0]                     cfg_freq,
    output logic [31:0]                     cfg_ampl,
    output logic [31:0]                     cfg_offset,
    output logic                            cfg_update
);

    logic         wr_commit;
    logic [1:0]   wr_idx;
    logic [31:0]  wr_data, wr_old, wr_val;
    logic [3:0]   wr_strb;
    sig_gen_cfg_t cfg_q, cfg_d;
    logic         cfg_update_q, cfg_update_d;
    logic         arready_q, arready_d;
    logic         rvalid_q, rvalid_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         ar_hs;
    logic         unused_ok;

    sig_gen_axil_wr_ctl u_wr_ctl (
        .clk       (s00_axi_aclk),
        .rst       (s00_axi_areset),
        .aw_idx    (s00_axi_awaddr[3:2]),
        .aw_valid  (s00_axi_awvalid),
        .aw_ready  (s00_axi_awready),
        .w_data    (s00_axi_wdata),
        .w_strb    (s00_axi_wstrb),
        .w_valid   (s00_axi_wvalid),
        .w_ready   (s00_axi_wready),
        .b_valid   (s00_axi_bvalid),
        .b_ready   (s00_axi_bready),
        .wr_commit (wr_commit),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .wr_strb   (wr_strb)
    );

    always_comb begin
        wr_old = cfg_field(cfg_q, wr_idx);
`ifdef SIG_GEN_AXIL_STRB_EN
        wr_val = wr_old;
        for (int k = 0; k < 4; k++) begin
            if (wr_strb[k]) wr_val[8*k +: 8] = wr_data[8*k +: 8];
        end
        cfg_update_d = wr_commit && (|wr_strb);
`else
        wr_val       = wr_data;
        cfg_update_d = wr_commit;
`endif
        cfg_d = cfg_q;
        if (wr_commit) begin
            unique case (wr_idx)
                REG_CTRL:   cfg_d.ctrl   = wr_val;
                REG_FREQ:   cfg_d.freq   = wr_val;
                REG_AMPL:   cfg_d.ampl   = wr_val;
                REG_OFFSET: cfg_d.offset = wr_val;
            endcase
        end
    end

    // Read samples cfg_q, so a same-edge write commit returns the old value.
    always_comb begin
        ar_hs    = s00_axi_arvalid && arready_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = cfg_field(cfg_q, s00_axi_araddr[3:2]);
        end else if (s00_axi_rready) begin
            rvalid_d = 1'b0;
        end
        arready_d = !rvalid_d;
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            cfg_q        <= '0;
            cfg_update_q <= 1'b0;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            cfg_q        <= cfg_d;
            cfg_update_q <= cfg_update_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign s00_axi_bresp   = RESP_OKAY;
    assign s00_axi_rresp   = RESP_OKAY;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign cfg_ctrl        = cfg_q.ctrl;
    assign cfg_freq        = cfg_q.freq;
    assign cfg_ampl        = cfg_q.ampl;
    assign cfg_offset      = cfg_q.offset;
    assign cfg_update      = cfg_update_q;

`ifdef SIG_GEN_AXIL_STRB_EN
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr, s00_axi_araddr};
`else
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr, s00_axi_araddr,
                         wr_strb, wr_old};
`endif

endmodule

// File: tb/tb_sig_gen_axil_regs.sv
// Directed self-checking bench for sig_gen_axil_regs.
// Strobe cases run only when SIG_GEN_AXIL_STRB_EN is defined.
module tb_sig_gen_axil_regs;

    logic        clk;
    logic        rst;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [31:0] cfg_ctrl, cfg_freq, cfg_ampl, cfg_offset;
    logic        cfg_update;

    int errors = 0;
    int checks = 0;
    int upd_cnt = 0;

    sig_gen_axil_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_areset  (rst),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .cfg_ctrl        (cfg_ctrl),
        .cfg_freq        (cfg_freq),
        .cfg_ampl        (cfg_ampl),
        .cfg_offset      (cfg_offset),
        .cfg_update      (cfg_update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (cfg_update === 1'b1) upd_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr_hs(input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        int n = 0;
        bit ad = 1'b0;
        bit wd = 1'b0;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        while (!(ad && wd) && n < 20) begin
            if (awvalid && awready) ad = 1'b1;
            if (wvalid && wready) wd = 1'b1;
            @(negedge clk);
            n++;
            if (ad) awvalid = 1'b0;
            if (wd) wvalid = 1'b0;
        end
        check("wr_hs", {30'd0, ad, wd}, 32'd3);
    endtask

    task automatic wait_b(input string tag);
        int n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_bvalid"}, bvalid, 1);
        check({tag, "_bresp"}, bresp, 0);
    endtask

    task automatic wr(input string tag, input logic [3:0] a,
                      input logic [31:0] d, input logic [3:0] s);
        wr_hs(a, d, s);
        wait_b(tag);
    endtask

    task automatic rd(input string tag, input logic [3:0] a,
                      input logic [31:0] exp);
        int n = 0;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        check({tag, "_rvalid"}, rvalid, 1);
        check({tag, "_rdata"}, rdata, exp);
        check({tag, "_rresp"}, rresp, 0);
    endtask

    initial begin
        int u0;
        bit seen;
        rst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = 4'hF; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_arready", arready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_ctrl", cfg_ctrl, 0);
        check("rst_offset", cfg_offset, 0);
        check("rst_update", cfg_update, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_awready", awready, 1);
        check("rel_wready", wready, 1);
        check("rel_arready", arready, 1);

        // basic writes and readback
        wr("w0", 4'h0, 32'h1, 4'hF);
        wr("w1", 4'h4, 32'h2, 4'hF);
        wr("w2", 4'h8, 32'h3, 4'hF);
        wr("w3", 4'hC, 32'h4, 4'hF);
        @(negedge clk);
        rd("r0", 4'h0, 32'h1);
        rd("r1", 4'h4, 32'h2);
        rd("r2", 4'h8, 32'h3);
        rd("r3", 4'hF, 32'h4);
        check("cfg_ctrl", cfg_ctrl, 32'h1);
        check("cfg_freq", cfg_freq, 32'h2);
        check("cfg_ampl", cfg_ampl, 32'h3);
        check("cfg_offset", cfg_offset, 32'h4);
        check("upd_cnt4", upd_cnt, 4);

        // W arrives well before AW
        @(negedge clk);
        wvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        check("wf_wready", wready, 1);
        @(negedge clk);
        wvalid = 1'b0;
        check("wf_wready_lo", wready, 0);
        repeat (4) @(negedge clk);
        check("wf_wready_hold", wready, 0);
        check("wf_nob", bvalid, 0);
        u0 = upd_cnt;
        awaddr = 4'h4; awvalid = 1'b1;
        check("wf_awready", awready, 1);
        @(negedge clk);
        awvalid = 1'b0;
        check("wf_b_early", bvalid, 0);
        @(negedge clk);
        check("wf_bvalid", bvalid, 1);
        check("wf_freq", cfg_freq, 32'hDEADBEEF);
        check("wf_update", cfg_update, 1);
        @(negedge clk);
        check("wf_update_lo", cfg_update, 0);
        check("wf_upd_once", upd_cnt - u0, 1);

        // B stall with bready low
        bready = 1'b0;
        wr("st", 4'h0, 32'h55, 4'hF);
        check("st_ctrl", cfg_ctrl, 32'h55);
        awaddr = 4'h0; awvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("st_bvalid", bvalid, 1);
            check("st_awready", awready, 0);
            check("st_wready", wready, 0);
        end
        bready = 1'b1;
        @(negedge clk);
        check("st_bclr", bvalid, 0);
        check("st_awready_hi", awready, 1);
        @(negedge clk);
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = 32'h66; wstrb = 4'hF;
        check("st2_wready", wready, 1);
        @(negedge clk);
        wvalid = 1'b0;
        wait_b("st2");
        check("st2_ctrl", cfg_ctrl, 32'h66);

        // same-edge read and write commit
        wr("se0", 4'h8, 32'h10, 4'hF);
        @(negedge clk);
        awaddr = 4'h8; wdata = 32'h20; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; araddr = 4'h8;
        check("se_awready", awready, 1);
        check("se_wready", wready, 1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b1;
        check("se_arready", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
        check("se_rvalid", rvalid, 1);
        check("se_rdata_old", rdata, 32'h10);
        check("se_ampl_new", cfg_ampl, 32'h20);
        check("se_bvalid", bvalid, 1);
        rd("se_rd", 4'h8, 32'h20);

`ifdef SIG_GEN_AXIL_STRB_EN
        wr("sb0", 4'hC, 32'h11223344, 4'hF);
        wr("sb1", 4'hC, 32'hAABBCCDD, 4'b0101);
        @(negedge clk);
        check("sb_merge", cfg_offset, 32'h11BB33DD);
        u0 = upd_cnt;
        wr("sb2", 4'hC, 32'hFFFFFFFF, 4'b0000);
        @(negedge clk);
        check("sb_none", cfg_offset, 32'h11BB33DD);
        check("sb_noupd", upd_cnt - u0, 0);
`endif

        // reset between AW and W
        @(negedge clk);
        awaddr = 4'h0; awvalid = 1'b1;
        check("ra_awready", awready, 1);
        @(negedge clk);
        awvalid = 1'b0;
        rst = 1'b1;
        wvalid = 1'b1; wdata = 32'h77; wstrb = 4'hF;
        @(negedge clk);
        check("ra_awready0", awready, 0);
        check("ra_wready0", wready, 0);
        check("ra_arready0", arready, 0);
        check("ra_bvalid0", bvalid, 0);
        check("ra_rdata0", rdata, 0);
        check("ra_ctrl0", cfg_ctrl, 0);
        check("ra_freq0", cfg_freq, 0);
        check("ra_ampl0", cfg_ampl, 0);
        check("ra_update0", cfg_update, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ra_awready1", awready, 1);
        check("ra_wready1", wready, 1);
        check("ra_arready1", arready, 1);
        @(negedge clk);
        wvalid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen |= bvalid;
            @(negedge clk);
        end
        check("ra_nob", seen, 0);
        rd("ra_r0", 4'h0, 32'h0);
        rd("ra_r1", 4'h4, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sig_gen_axil_regs.md
# sig_gen_axil_regs

AXI4-Lite slave register file for the signal generator. It is the responder end of the S00_AXI control port driven by the master VIP. It accepts single-beat AXI4-Lite writes and reads to four 32-bit read/write configuration registers, and drives those registers, plus an update strobe, into the generator core. At most one write and one read are outstanding at a time; write and read channels are fully independent.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; decode uses bits [3:2].
- s00_axi_aclk  in  1  sole clock; everything is sampled on the rising edge.
- s00_axi_areset  in  1  reset, synchronous and active-high.
- s00_axi_awaddr / awprot / awvalid / awready  in/in/in/out  4/3/1/1  write address channel; awprot is ignored.
- s00_axi_wdata / wstrb / wvalid / wready  in/in/in/out  32/4/1/1  write data channel.
- s00_axi_bresp / bvalid / bready  out/out/in  2/1/1  write response.
- s00_axi_araddr / arprot / arvalid / arready  in/in/in/out  4/3/1/1  read address channel; arprot is ignored.
- s00_axi_rdata / rresp / rvalid / rready  out/out/out/in  32/2/1/1  read data channel.
- cfg_ctrl, cfg_freq, cfg_ampl, cfg_offset  out  32 each  current register values (offsets 0x0, 0x4, 0x8, 0xC).
- cfg_update  out  1  one-cycle pulse in the cycle a committed write changes any register.

## Operation
- Register map: idx = addr[3:2]. 0 CTRL, 1 FREQ, 2 AMPL, 3 OFFSET. All four are plain read/write registers and read back exactly what was written. addr[1:0] is ignored.
- Write path. AW slot and W slot each hold one beat.
  - awready = AW slot empty AND !bvalid. wready = W slot empty AND !bvalid.
  - AW and W may arrive in either order or in the same cycle.
- Commit: in the cycle both slots are full, the write is performed at the next edge.
  - The register is updated (strobe handling per Configuration), both slots clear, bvalid=1, bresp=OKAY (2'b00), and cfg_update pulses.
- bvalid holds until bready is sampled high. No new AW or W is accepted while bvalid=1.
- Read path: arready = !rvalid. An AR handshake at edge N loads rdata from the addressed register and sets rvalid=1, rresp=OKAY. rvalid holds with stable rdata until rready.
- Same-edge read and write commit to the same register: rdata returns the pre-write value.
- No SLVERR/DECERR is ever generated, because all four addresses are mapped.
- Reset:
  - All registers, cfg_* and cfg_update go to 0.
  - bvalid, rvalid, bresp, rresp and rdata go to 0.
  - awready, wready and arready are 0 during reset and 1 in the first cycle after reset deasserts.
  - Slots are cleared. An in-flight write is discarded with no B response.

## Timing
- Write latency: the edge that fills the second slot is T. At T+1, bvalid=1, the register holds its new value and cfg_update=1. cfg_update=0 at T+2.
- Back-to-back writes: with bready held high, bvalid clears at T+2 and the readies are high again at T+2. Minimum spacing between writes is 3 cycles.
- Read latency: AR handshake at edge N gives rvalid=1 at N+1. With rready held high, arready is high again at N+2.
- All outputs are registered; no combinational path from any input to any output.

## Configuration
- SIG_GEN_AXIL_STRB_EN defined: byte lane k is written only when wstrb[k]=1. A write with wstrb=0 still completes with OKAY, but cfg_update stays 0.
- SIG_GEN_AXIL_STRB_EN undefined: wstrb is ignored, every write updates all 32 bits, and cfg_update always pulses.

## Structure
- Package sig_gen_pkg holds:
  - register index constants REG_CTRL=0, REG_FREQ=1, REG_AMPL=2, REG_OFFSET=3;
  - AXI response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - typedef sig_gen_cfg_t, a packed struct of the four 32-bit registers.
- One sub-module, sig_gen_axil_wr_ctl, handles AW/W slot capture, commit detection and the B handshake. The top level holds the register array, strobe merge and read path.

## Test plan
- Write 0x1, 0x2, 0x3, 0x4 to offsets 0x0–0xC, then read them back -> rdata 0x1..0x4, all bresp/rresp OKAY, cfg_ctrl..cfg_offset = 1..4.
- Present W 5 cycles before AW (addr 0x4, data 0xDEADBEEF) -> wready drops after the W handshake; bvalid is 1 cycle after the AW handshake; cfg_freq=0xDEADBEEF; single cfg_update pulse.
- Hold bready=0 for 10 cycles after a write -> bvalid stays 1, awready/wready stay 0; a second AW is stalled until bready=1.
- Same-edge AR and write commit to 0x8 (old 0x10, new 0x20) -> rdata=0x10; a subsequent read returns 0x20.
- With SIG_GEN_AXIL_STRB_EN: write 0xAABBCCDD with wstrb=0b0101 over 0x11223344 at 0xC -> cfg_offset=0x11BB33DD. With wstrb=0 -> value unchanged, OKAY, no cfg_update.
- Assert reset between the AW and W handshakes -> all outputs 0, no bvalid ever; after release, readies =1 next cycle and registers read 0.
